// File: rtl/uart_terminal_rx_pkg.sv
// rtl/uart_terminal_rx_pkg.sv - shared receiver state encoding and terminal ASCII constants
package uart_terminal_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_e;

    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_DEL = 8'h7F;

endpackage

// File: rtl/uart_bit_rx.sv
// rtl/uart_bit_rx.sv - UART line synchronizer and 8N1 framing FSM
module uart_bit_rx
    import uart_terminal_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_BITS     = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       frame_error_o,
    output logic       busy_o
);

    localparam logic [CNT_BITS-1:0] HALF_LOAD = CNT_BITS'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_BITS-1:0] FULL_LOAD = CNT_BITS'(CLKS_PER_BIT - 1);

    logic [1:0]          sync_q;
    rx_state_e           state_q;
    logic [CNT_BITS-1:0] timer_q;
    logic [2:0]          bit_idx_q;
    logic [7:0]          data_q;
    logic                rx_s;
    logic                expired;

    assign rx_s    = sync_q[1];
    assign expired = (timer_q == '0);

    // Stop-bit verdicts are strobes in the sampling cycle; the top registers them.
    assign valid_o       = (state_q == ST_STOP) && expired && rx_s;
    assign frame_error_o = (state_q == ST_STOP) && expired && !rx_s;
    assign byte_o        = data_q;
    assign busy_o        = (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= 2'b11;
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
        end else begin
            sync_q <= {sync_q[0], rx};
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_q <= ST_START;
                        timer_q <= HALF_LOAD;
                    end
                end
                ST_START: begin
                    if (!expired) begin
                        timer_q <= timer_q - 1'b1;
                    end else if (rx_s) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q   <= ST_DATA;
                        timer_q   <= FULL_LOAD;
                        bit_idx_q <= '0;
                    end
                end
                ST_DATA: begin
                    if (!expired) begin
                        timer_q <= timer_q - 1'b1;
                    end else begin
                        data_q    <= {rx_s, data_q[7:1]};
                        timer_q   <= FULL_LOAD;
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (!expired) begin
                        timer_q <= timer_q - 1'b1;
                    end else if (rx_s) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_WAIT_HIGH;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_terminal_rx.sv
// rtl/uart_terminal_rx.sv - UART receiver with terminal character translation
module uart_terminal_rx
    import uart_terminal_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_BITS     = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       add_char,
    output logic [6:0] char_value,
    output logic       frame_error,
    output logic       rx_busy
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ferr;

    logic       add_char_q;
    logic [6:0] char_value_q;
    logic       frame_error_q;
    logic       cr_seen_q;

    logic       emit_d;
    logic [6:0] value_d;

    uart_bit_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_BITS    (CNT_BITS)
    ) u_bit_rx (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .byte_o       (rx_byte),
        .valid_o      (rx_valid),
        .frame_error_o(rx_ferr),
        .busy_o       (rx_busy)
    );

    // CR becomes LF, so the LF of a CRLF pair is swallowed to avoid a double newline.
    always_comb begin
        emit_d  = 1'b0;
        value_d = rx_byte[6:0];
        if (rx_byte == ASCII_CR) begin
            value_d = ASCII_LF[6:0];
        end else if (rx_byte == ASCII_DEL) begin
            value_d = ASCII_BS[6:0];
        end
        if (rx_valid) begin
            emit_d = !rx_byte[7] && !((rx_byte == ASCII_LF) && cr_seen_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            add_char_q    <= 1'b0;
            char_value_q  <= '0;
            frame_error_q <= 1'b0;
            cr_seen_q     <= 1'b0;
        end else begin
            add_char_q    <= emit_d;
            frame_error_q <= rx_ferr;
            if (emit_d) begin
                char_value_q <= value_d;
            end
            if (rx_valid) begin
                cr_seen_q <= (rx_byte == ASCII_CR);
            end
        end
    end

    assign add_char    = add_char_q;
    assign char_value  = char_value_q;
    assign frame_error = frame_error_q;

endmodule

// File: tb/tb_uart_terminal_rx.sv
// tb/tb_uart_terminal_rx.sv - directed self-checking bench for uart_terminal_rx
module tb_uart_terminal_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       add_char;
    logic [6:0] char_value;
    logic       frame_error;
    logic       rx_busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_cyc = 0;

    int         strobe_total = 0;
    int         fe_total = 0;
    int         both_total = 0;
    logic [6:0] last_val = '0;
    int         last_cyc = 0;
    int         prev_cyc = 0;

    int s0;
    int f0;

    uart_terminal_rx #(
        .CLKS_PER_BIT(CPB),
        .CNT_BITS    (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .add_char   (add_char),
        .char_value (char_value),
        .frame_error(frame_error),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (add_char) begin
            strobe_total++;
            last_val = char_value;
            prev_cyc = last_cyc;
            last_cyc = cyc;
        end
        if (frame_error) fe_total++;
        if (add_char && frame_error) both_total++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Leaves rx at the stop-bit level when it returns.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        start_cyc = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_ok(input logic [7:0] b);
        send_frame(b, 1'b1);
    endtask

    task automatic pulse_reset(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic snap();
        s0 = strobe_total;
        f0 = fe_total;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_add_char", 32'(add_char), 0);
        check("rst_frame_error", 32'(frame_error), 0);
        check("rst_char_value", 32'(char_value), 0);
        check("rst_rx_busy", 32'(rx_busy), 0);
        idle(10);

        // 'A': 2 sync + 1 detect + 8 half bit + 9*16 bits -> strobe 155 cycles after the start edge
        snap();
        send_ok(8'h41);
        idle(20);
        check("A_count", strobe_total - s0, 1);
        check("A_value", 32'(last_val), 32'h41);
        check("A_latency", last_cyc - start_cyc, 155);
        check("A_ferr", fe_total - f0, 0);
        check("A_idle_busy", 32'(rx_busy), 0);

        // CR LF -> single LF, then lone LF passes
        snap();
        send_ok(8'h0D);
        send_ok(8'h0A);
        idle(20);
        check("crlf_count", strobe_total - s0, 1);
        check("crlf_value", 32'(last_val), 32'h0A);
        snap();
        send_ok(8'h0A);
        idle(20);
        check("lf_count", strobe_total - s0, 1);
        check("lf_value", 32'(last_val), 32'h0A);

        // DEL -> BS; high-bit byte dropped, char_value holds
        snap();
        send_ok(8'h7F);
        send_ok(8'hC1);
        idle(20);
        check("del_count", strobe_total - s0, 1);
        check("del_value", 32'(last_val), 32'h08);
        check("hold_value", 32'(char_value), 32'h08);
        check("high_ferr", fe_total - f0, 0);

        // Back-to-back frames: strobes 160 cycles apart
        snap();
        send_ok(8'h61);
        send_ok(8'h62);
        idle(20);
        check("b2b_count", strobe_total - s0, 2);
        check("b2b_value", 32'(last_val), 32'h62);
        check("b2b_spacing", last_cyc - prev_cyc, 10 * CPB);

        // Bad stop bit, line held low, then a good frame
        snap();
        send_frame(8'h55, 1'b0);
        repeat (40) @(negedge clk);
        check("werr_busy", 32'(rx_busy), 1);
        idle(20);
        send_ok(8'h42);
        idle(20);
        check("ferr_count", fe_total - f0, 1);
        check("ferr_strobes", strobe_total - s0, 1);
        check("ferr_value", 32'(last_val), 32'h42);

        // Framing error does not clear the CR flag
        snap();
        send_ok(8'h0D);
        send_frame(8'h00, 1'b0);
        idle(20);
        send_ok(8'h0A);
        idle(20);
        check("crflag_ferr_count", strobe_total - s0, 1);
        check("crflag_ferr_fe", fe_total - f0, 1);

        // 5-cycle glitch
        snap();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy", 32'(rx_busy), 1);
        @(negedge clk);
        idle(30);
        check("glitch_count", strobe_total - s0, 0);
        check("glitch_ferr", fe_total - f0, 0);
        check("glitch_idle", 32'(rx_busy), 0);

        // Reset during data bit 4 of 0xA5, then 0x31
        snap();
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = 8'hA5 >> i;
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_busy", 32'(rx_busy), 0);
        check("midrst_value", 32'(char_value), 0);
        reset = 1'b0;
        idle(200);
        check("midrst_count", strobe_total - s0, 0);
        send_ok(8'h31);
        idle(20);
        check("after_rst_count", strobe_total - s0, 1);
        check("after_rst_value", 32'(last_val), 32'h31);

        // Reset clears the CR flag
        snap();
        send_ok(8'h0D);
        idle(10);
        pulse_reset(2);
        idle(10);
        send_ok(8'h0A);
        idle(20);
        check("rst_crflag_count", strobe_total - s0, 2);
        check("rst_crflag_value", 32'(last_val), 32'h0A);

        check("never_both", both_total, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
